// File: rtl/fifo_packer.sv
// rtl/fifo_packer.sv - packs RATIO narrow beats into wide words buffered in a DEPTH-entry FIFO
// Flags are registered from next-state word count; the word memory itself is not reset.
module fifo_packer #(
  parameter int IN_W     = 8,
  parameter int RATIO    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wn,
  input  logic [IN_W-1:0]           DATAIN,
  input  logic                      rn,
  output logic [IN_W*RATIO-1:0]     DATAOUT,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    word_count,
  output logic [$clog2(RATIO):0]    beat_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = $clog2(RATIO) + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C      = CW'(AE_LEVEL);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  logic [OUT_W-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [OUT_W-1:0] pack_q, pack_d, dout_q, dout_d, word_nxt;
  logic             full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic             ovf_d, unf_d;
  logic             wr_ok, rd_ok, word_done, mem_we;

  always_comb begin
    wr_ok     = wn & ~full_q;
    rd_ok     = rn & ~empty_q;
    word_done = wr_ok & (beat_q == LAST_BEAT);

    // Current beat merged into its lane; on the last beat this is the complete word.
    word_nxt = pack_q;
    for (int k = 0; k < RATIO; k++) begin
      if (beat_q == BW'(k)) word_nxt[k*IN_W +: IN_W] = DATAIN;
    end

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    beat_d = beat_q;
    pack_d = pack_q;
    dout_d = dout_q;
    mem_we = word_done & ~flush;

    if (wr_ok) begin
      if (word_done) begin
        pack_d = '0;
        beat_d = '0;
        wptr_d = wptr_q + AW'(1);
      end else begin
        pack_d = word_nxt;
        beat_d = beat_q + BW'(1);
      end
    end
    if (rd_ok) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem[rptr_q];
    end

    cnt_d = cnt_q + CW'(word_done) - CW'(rd_ok);
    ovf_d = ovf_q | (wn & full_q);
    unf_d = unf_q | (rn & empty_q);

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      beat_d = '0;
      pack_d = '0;
      dout_d = dout_q;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[wptr_q] <= word_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      pack_q   <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      pack_q   <= pack_d;
      dout_q   <= dout_d;
      full_q   <= (cnt_d == DEPTH_C);
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= AF_C);
      aempty_q <= (cnt_d <= AE_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign DATAOUT      = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign word_count   = cnt_q;
  assign beat_count   = beat_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_packer.sv
// tb/tb_fifo_packer.sv - random and directed checks of fifo_packer against a queue-based model
module tb_fifo_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        wn = 1'b0;
  logic        rn = 1'b0;
  logic [7:0]  DATAIN = '0;
  logic [31:0] DATAOUT;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  word_count;
  logic [2:0]  beat_count;

  fifo_packer dut (
    .clock(clock), .reset(reset), .flush(flush), .wn(wn), .DATAIN(DATAIN), .rn(rn),
    .DATAOUT(DATAOUT), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .word_count(word_count), .beat_count(beat_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: stored words, the partial word, beats held, output register, sticky flags.
  logic [31:0] m_q[$];
  logic [31:0] m_part;
  int          m_beats;
  logic [31:0] m_dout;
  logic        m_ovf, m_unf;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part  = '0;
    m_beats = 0;
    m_dout  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit f);
    int  n;
    bit  was_full, was_empty;
    n = m_q.size();
    if (f) begin
      m_q.delete();
      m_part  = '0;
      m_beats = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      return;
    end
    was_full  = (n == 16);
    was_empty = (n == 0);
    if (r) begin
      if (was_empty) m_unf = 1'b1;
      else m_dout = m_q.pop_front();
    end
    if (w) begin
      if (was_full) m_ovf = 1'b1;
      else begin
        m_part[m_beats*8 +: 8] = d;
        m_beats++;
        if (m_beats == 4) begin
          m_q.push_back(m_part);
          m_part  = '0;
          m_beats = 0;
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("dataout",      DATAOUT,      m_dout);
      check("word_count",   32'(word_count), 32'(m_q.size()));
      check("beat_count",   32'(beat_count), 32'(m_beats));
      check("full",         32'(full),         32'(m_q.size() == 16));
      check("empty",        32'(empty),        32'(m_q.size() == 0));
      check("almost_full",  32'(almost_full),  32'(m_q.size() >= 14));
      check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 2));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    wn = w; DATAIN = d; rn = r; flush = f;
    @(posedge clock);
    model_step(w, d, r, f);
    #1;
    wn = 1'b0; rn = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic write_beat(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic read_word();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] held;
    int pw, pr;
    model_reset();
    chk_en = 1'b1;
    @(posedge clock);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_dout", DATAOUT, 32'h0);
    reset = 1'b1;

    write_beat(8'h11); write_beat(8'h22); write_beat(8'h33); write_beat(8'h44);
    check("pack_wc", 32'(word_count), 32'd1);
    check("pack_empty", 32'(empty), 32'd0);
    read_word();
    check("pack_dout", DATAOUT, 32'h44332211);
    check("pack_empty_after", 32'(empty), 32'd1);

    for (int i = 0; i < 64; i++) write_beat(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_wc", 32'(word_count), 32'd16);
    write_beat(8'hEE);
    check("fill_ovf", 32'(overflow), 32'd1);
    read_word();
    check("fill_first", DATAOUT, 32'h03020100);
    for (int i = 1; i < 16; i++) read_word();
    check("fill_last", DATAOUT, 32'h3F3E3D3C);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) write_beat(8'(8'h80 + i));
    for (int i = 0; i < 8; i++) read_word();
    for (int i = 0; i < 48; i++) write_beat(8'(i));
    check("wrap_wc", 32'(word_count), 32'd14);
    check("wrap_af", 32'(almost_full), 32'd1);
    read_word();
    check("wrap_old", DATAOUT, 32'hA3A2A1A0);
    for (int i = 1; i < 14; i++) read_word();
    check("wrap_newlast", DATAOUT, 32'h2F2E2D2C);

    for (int i = 0; i < 23; i++) write_beat(8'(8'hA0 + i));
    step(1'b1, 8'hB7, 1'b1, 1'b0);
    check("sim_wc", 32'(word_count), 32'd5);
    check("sim_dout", DATAOUT, 32'hA3A2A1A0);
    for (int i = 0; i < 5; i++) read_word();

    held = DATAOUT;
    read_word();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_hold", DATAOUT, held);
    write_beat(8'h01);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    check("flush_beat", 32'(beat_count), 32'd0);
    check("flush_unf", 32'(underflow), 32'd0);

    for (int i = 0; i < 11; i++) write_beat(8'(8'hC0 + i));
    do_reset();
    check("rst2_wc", 32'(word_count), 32'd0);
    check("rst2_empty", 32'(empty), 32'd1);
    write_beat(8'h51); write_beat(8'h52); write_beat(8'h53); write_beat(8'h54);
    read_word();
    check("rst2_fresh", DATAOUT, 32'h54535251);

    for (int e = 0; e < 30; e++) begin
      pw = $urandom_range(10, 95);
      pr = $urandom_range(0, 45);
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int c = 0; c < 100; c++) begin
        step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) == 0);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
